// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Start/done handshake bundle between the controlling logic and the bit-serial
//   subtractor.
//   master : drives start, a, b; observes busy, done, diff, bout
//   slave  : the subtractor itself
//   start  request a subtraction (only honoured while the subtractor is idle)
//   a, b   minuend / subtrahend, captured on the accepting edge
//   busy   operation in progress (shifting or presenting the result)
//   done   one-cycle pulse, diff/bout valid
//   diff   a-b mod 2^WIDTH, held until the next result
//   bout   final borrow, 1 when a < b (unsigned)
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit unsigned subtractor. Operands are shifted LSB-first
//   through a single one-bit full-subtract cell with a registered borrow; the
//   difference is collected MSB-inserted in a result shift register and
//   published to diff/bout only when the last bit has been processed.
//   Latency: start accepted at edge E, done high in the cycle after E+WIDTH.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    serial_subtractor_if slave (start, a, b, busy, done, diff, bout)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_bnext;
  logic             w_last;
  logic             w_accept;
  logic             w_shift;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_res_next;

  // One-bit full-subtract cell on the current LSBs and the carried borrow.
  assign w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_borrow;
  assign w_bnext    = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_borrow);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    w_shift  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy  = 1'b1;
        w_shift = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        // Unused encoding: recover to IDLE without driving any handshake.
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= bus.a;
      r_b_sr   <= bus.b;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_shift) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_bnext;
      r_cnt    <= r_cnt + CNT_W'(1);
      // Publish only on the final bit so diff/bout never show partial results.
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_bnext;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule
